// File: rtl/moore_1100_detector_if.sv
// rtl/moore_1100_detector_if.sv - serial bit in, detect flag and debug state/count out
interface moore_1100_detector_if #(
  parameter int CNT_W = 8
);
  logic             in;
  logic             z;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] match_count;

  modport master (
    output in,
    input  z,
    input  state_o,
    input  match_count
  );

  modport slave (
    input  in,
    output z,
    output state_o,
    output match_count
  );
endinterface

// File: rtl/moore_1100_detector.sv
// rtl/moore_1100_detector.sv - Moore FSM detecting serial 1100 with saturating match counter
module moore_1100_detector #(
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  moore_1100_detector_if.slave  det
);

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // 1100 has no self-overlap, so S4 restarts as if from S0.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = det.in ? S1 : S0;
      S1:      state_d = det.in ? S2 : S0;
      S2:      state_d = det.in ? S2 : S3;
      S3:      state_d = det.in ? S1 : S4;
      S4:      state_d = det.in ? S1 : S0;
      default: state_d = S0;
    endcase
  end

  // Count on entry to S4 so the count moves on the same edge z rises.
  always_comb begin
    count_d = count_q;
    if ((state_d == S4) && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_comb begin
    det.z = 1'b0;
    case (state_q)
      S4:      det.z = 1'b1;
      default: det.z = 1'b0;
    endcase
  end

  assign det.state_o     = state_q;
  assign det.match_count = count_q;

endmodule

// File: tb/tb_moore_1100_detector.sv
// tb/tb_moore_1100_detector.sv - scoreboard bench for the 1100 detector at CNT_W=8 and CNT_W=2
module tb_moore_1100_detector;

  typedef struct packed {
    logic [2:0] st;
    logic       z;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [3:0] hist;
  int         exp_c8;
  int         exp_c2;
  exp_t       sb[$];

  moore_1100_detector_if #(.CNT_W(8)) if8 ();
  moore_1100_detector_if #(.CNT_W(2)) if2 ();

  moore_1100_detector #(.CNT_W(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .det   (if8)
  );

  moore_1100_detector #(.CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .det   (if2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // State reconstructed from the most recent bits, independent of the transition table.
  function automatic logic [2:0] model_state(input logic [3:0] h);
    if (h == 4'b1100)           return 3'b100;
    else if (h[2:0] == 3'b110)  return 3'b011;
    else if (h[1:0] == 2'b11)   return 3'b010;
    else if (h[0])              return 3'b001;
    else                        return 3'b000;
  endfunction

  task automatic model_reset();
    hist   = 4'b0000;
    exp_c8 = 0;
    exp_c2 = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_state"}, 32'(if8.state_o), 32'd0);
    check_val({tag, "_z"}, 32'(if8.z), 32'd0);
    check_val({tag, "_cnt8"}, 32'(if8.match_count), 32'd0);
    check_val({tag, "_cnt2"}, 32'(if2.match_count), 32'd0);
    check_val({tag, "_state2"}, 32'(if2.state_o), 32'd0);
  endtask

  // Called between edges: drives a bit, predicts the post-edge result, then compares.
  task automatic send_bit(input logic b);
    exp_t e;
    exp_t got;
    if8.in = b;
    if2.in = b;
    hist   = {hist[2:0], b};
    if (hist == 4'b1100) begin
      if (exp_c8 < 255) exp_c8++;
      if (exp_c2 < 3)   exp_c2++;
    end
    e.st = model_state(hist);
    e.z  = (hist == 4'b1100);
    e.c8 = 8'(exp_c8);
    e.c2 = 2'(exp_c2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_val("state", 32'(if8.state_o), 32'(got.st));
    check_val("z", 32'(if8.z), 32'(got.z));
    check_val("cnt8", 32'(if8.match_count), 32'(got.c8));
    check_val("state_w2", 32'(if2.state_o), 32'(got.st));
    check_val("z_w2", 32'(if2.z), 32'(got.z));
    check_val("cnt2", 32'(if2.match_count), 32'(got.c2));
  endtask

  task automatic send_seq(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(bits[i]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    if8.in   = 1'b1;
    if2.in   = 1'b1;
    model_reset();

    #3;
    check_reset_state("reset_init");
    // Edges while reset is held must not advance anything.
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset_held");

    @(negedge clk);
    reset = 1'b1;

    send_seq(16'b1100, 4);
    check_val("basic_cnt", 32'(if8.match_count), 32'd1);

    send_seq(16'b0, 1);
    model_reset();
    reset = 1'b0;
    #1;
    check_reset_state("reset_stream");
    reset = 1'b1;

    send_seq(16'b110011101, 9);
    check_val("stream_state", 32'(if8.state_o), 32'd1);
    check_val("stream_cnt", 32'(if8.match_count), 32'd1);

    send_seq(16'b0, 1);
    model_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;

    send_seq(16'b11001100, 8);
    check_val("b2b_cnt", 32'(if8.match_count), 32'd2);

    send_seq(16'b100, 3);
    send_seq(16'b11010, 5);
    check_val("near_miss_cnt", 32'(if8.match_count), 32'd2);

    // Partial match thrown away by an asynchronous reset between edges.
    send_seq(16'b110, 3);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_state("reset_mid");
    #1;
    reset = 1'b1;
    send_bit(1'b0);
    check_val("after_mid_state", 32'(if8.state_o), 32'd0);

    for (int k = 0; k < 5; k++) begin
      send_seq(16'b1100, 4);
    end
    check_val("sat_cnt2", 32'(if2.match_count), 32'd3);
    check_val("sat_cnt8", 32'(if8.match_count), 32'd5);

    for (int k = 0; k < 40; k++) begin
      send_bit(1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
